// File: rtl/frame_sync_descrambler.sv
// frame_sync_descrambler: hunts a sync word, then descrambles x^7+x^6+1 additive-scrambled frames.
// Optional SYNC_ERR_CNT_EN adds a saturating sync-mismatch counter and a lock_lost pulse.
module frame_sync_descrambler #(
  parameter int                  SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 8'hB4,
  parameter int                  FRAME_LEN = 16,
  parameter logic [6:0]          SEED      = 7'h7F,
  parameter int                  MISS_MAX  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       serial_in,
  output logic       descrambled_out,
  output logic       data_valid,
  output logic       locked,
  output logic       frame_start
`ifdef SYNC_ERR_CNT_EN
  ,
  output logic [7:0] sync_err_cnt,
  output logic       lock_lost
`endif
);
  localparam int BW = $clog2(FRAME_LEN + 1);
  typedef enum logic [1:0] {HUNT, LOCKED, CHECK} state_t;
  state_t              state_q;
  logic [SYNC_LEN-2:0] sr_q;
  logic [6:0]          lfsr_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [4:0]          sc_q;
  logic [3:0]          miss_cnt_q;
  logic [SYNC_LEN-1:0] win;
  logic                fb, sync_ok, last_bit, last_sync, drop;
  assign win       = {sr_q, serial_in};
  assign fb        = lfsr_q[6] ^ lfsr_q[5];
  assign sync_ok   = win == SYNC_WORD;
  assign last_bit  = bit_cnt_q == BW'(FRAME_LEN - 1);
  assign last_sync = sc_q == 5'(SYNC_LEN - 1);
  assign drop      = ({1'b0, miss_cnt_q} + 5'd1) >= 5'(MISS_MAX);
  assign locked    = state_q != HUNT;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= HUNT;
      sr_q            <= '0;
      lfsr_q          <= SEED;
      bit_cnt_q       <= '0;
      sc_q            <= '0;
      miss_cnt_q      <= '0;
      descrambled_out <= 1'b0;
      data_valid      <= 1'b0;
      frame_start     <= 1'b0;
`ifdef SYNC_ERR_CNT_EN
      sync_err_cnt    <= '0;
      lock_lost       <= 1'b0;
`endif
    end else begin
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
`ifdef SYNC_ERR_CNT_EN
      lock_lost   <= 1'b0;
`endif
      if (enable) begin
        sr_q <= win[SYNC_LEN-2:0];
        case (state_q)
          HUNT: if (sync_ok) begin
            state_q     <= LOCKED;
            lfsr_q      <= SEED;
            bit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            frame_start <= 1'b1;
          end
          LOCKED: begin
            descrambled_out <= serial_in ^ fb;
            data_valid      <= 1'b1;
            lfsr_q          <= {lfsr_q[5:0], fb};
            bit_cnt_q       <= last_bit ? '0 : bit_cnt_q + 1'b1;
            sc_q            <= '0;
            if (last_bit) state_q <= CHECK;
          end
          CHECK: if (!last_sync) sc_q <= sc_q + 5'd1;
          else begin
            lfsr_q <= SEED;
            if (sync_ok) begin
              miss_cnt_q  <= '0;
              frame_start <= 1'b1;
              state_q     <= LOCKED;
            end else begin
              // a miss either freewheels through another frame or, at the limit, drops lock
              miss_cnt_q <= drop ? 4'd0 : miss_cnt_q + 4'd1;
              state_q    <= drop ? HUNT : LOCKED;
`ifdef SYNC_ERR_CNT_EN
              if (sync_err_cnt != 8'hFF) sync_err_cnt <= sync_err_cnt + 8'd1;
              lock_lost <= drop;
`endif
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end
endmodule
